// File: rtl/code_packer_pkg.sv
// Shared definitions for code_packer: FSM state encoding and helpers that
// derive the size-port width and the byte-lane / stuffer-buffer geometry.
package code_packer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH = 16;

  // Bits needed to express a code length of 0..in_w.
  function automatic int size_bits(input int in_w);
    return $clog2(in_w + 1);
  endfunction

  // Bytes per output word.
  function automatic int byte_lanes(input int out_w);
    return out_w / 8;
  endfunction

  // Stuffer buffer depth in bytes: one partial word plus one fully stuffed word.
  function automatic int stuff_depth(input int out_w);
    return 3 * (out_w / 8) - 1;
  endfunction

endpackage

// File: rtl/code_packer_byte_stuffer.sv
// byte_stuffer: word-in / word-out stage that inserts a 0x00 byte after every
// 0xFF byte. Output bytes straddle word boundaries freely; on a pad request a
// trailing partial word is completed with 0x00 bytes. One cycle of latency.
module byte_stuffer
  import code_packer_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [OUT_WIDTH-1:0] in_word,
  input  logic                 pad,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [OUT_WIDTH-1:0] out_word,
  output logic                 empty
);
  localparam int L  = byte_lanes(OUT_WIDTH);
  localparam int D  = stuff_depth(OUT_WIDTH);
  localparam int BW = D * 8;
  localparam int NW = $clog2(D + 1);

  logic [BW-1:0] buff, buff_nx;
  logic [NW-1:0] bcnt, bcnt_nx, base_n, pos;
  logic [7:0]    b;
  logic          emit;

  assign out_vld  = bcnt >= NW'(L);
  assign emit     = out_vld && out_rdy;
  assign base_n   = emit ? (bcnt - NW'(L)) : bcnt;
  // A full word may double in size, so accept only when that still fits.
  assign in_rdy   = base_n < NW'(L);
  assign out_word = buff[BW-1 -: OUT_WIDTH];
  assign empty    = bcnt == '0;

  // Next buffer: drop the emitted word, then append the stuffed input bytes.
  always_comb begin
    buff_nx = emit ? (buff << OUT_WIDTH) : buff;
    bcnt_nx = base_n;
    pos     = base_n;
    b       = '0;
    if (in_vld && in_rdy) begin
      for (int i = 0; i < L; i++) begin
        b       = in_word[OUT_WIDTH-1-8*i -: 8];
        buff_nx = buff_nx | ({b, {(BW-8){1'b0}}} >> (8 * int'(pos)));
        // The inserted 0x00 is just an untouched (already zero) slot.
        pos     = pos + ((b == 8'hFF) ? NW'(2) : NW'(1));
      end
      bcnt_nx = pos;
    end else if (pad && (bcnt != '0) && (bcnt < NW'(L))) begin
      bcnt_nx = NW'(L);
    end
  end

  // Buffer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buff <= '0;
      bcnt <= '0;
    end else begin
      buff <= buff_nx;
      bcnt <= bcnt_nx;
    end
  end

endmodule

// File: rtl/code_packer.sv
// code_packer: packs variable-length codes MSB-first into OUT_WIDTH-bit words,
// with flush (pad with PAD_BIT, drain, done pulse). Defining the macro
// CODE_PACKER_STUFF_EN inserts a byte_stuffer (0xFF -> 0xFF 0x00) on the output.
module code_packer
  import code_packer_pkg::*;
#(
  parameter int   IN_WIDTH  = DEF_IN_WIDTH,
  parameter int   OUT_WIDTH = DEF_OUT_WIDTH,
  parameter logic PAD_BIT   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena_in,
  output logic                          rdy_out,
  input  logic [IN_WIDTH-1:0]           code,
  input  logic [$clog2(IN_WIDTH+1)-1:0] size,
  input  logic                          flush,
  output logic                          ena_out,
  input  logic                          rdy_in,
  output logic [OUT_WIDTH-1:0]          out,
  output logic                          done
);
  localparam int SW = size_bits(IN_WIDTH);
  localparam int AW = OUT_WIDTH + IN_WIDTH;
  localparam int CW = $clog2(AW + 1);

  state_t        state, state_nx;
  logic [AW-1:0] acc, acc_nx, acc_base, code_ext, pad_fill;
  logic [CW-1:0] cnt, cnt_nx, cnt_base;
  logic [SW-1:0] sz;
  logic          live, accept, word_vld, word_rdy, word_xfer, stuff_empty;

  // Accept only while the accumulator cannot overflow with a full-size code.
  assign rdy_out   = live && (state == RUN) && (cnt <= CW'(OUT_WIDTH));
  assign accept    = ena_in && rdy_out;
  assign word_vld  = cnt >= CW'(OUT_WIDTH);
  assign word_xfer = word_vld && word_rdy;

`ifdef CODE_PACKER_STUFF_EN
  logic drain_pad;
  assign drain_pad = (state == DRAIN) && (cnt == '0);

  byte_stuffer #(.OUT_WIDTH(OUT_WIDTH)) u_stuffer (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (word_vld),
    .in_rdy   (word_rdy),
    .in_word  (acc[AW-1 -: OUT_WIDTH]),
    .pad      (drain_pad),
    .out_vld  (ena_out),
    .out_rdy  (rdy_in),
    .out_word (out),
    .empty    (stuff_empty)
  );
`else
  assign word_rdy    = rdy_in;
  assign ena_out     = word_vld;
  assign out         = acc[AW-1 -: OUT_WIDTH];
  assign stuff_empty = 1'b1;
`endif

  // Next-state / datapath: emit first, then append, pad or clear.
  always_comb begin
    acc_base = word_xfer ? (acc << OUT_WIDTH) : acc;
    cnt_base = word_xfer ? (cnt - CW'(OUT_WIDTH)) : cnt;
    sz       = (size > SW'(IN_WIDTH)) ? SW'(IN_WIDTH) : size;
    code_ext = AW'(code) & ~({AW{1'b1}} << sz);
    pad_fill = ({AW{1'b1}} >> cnt) & ~({AW{1'b1}} >> OUT_WIDTH);
    acc_nx   = acc_base;
    cnt_nx   = cnt_base;
    state_nx = state;
    done     = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          acc_nx = acc_base | (code_ext << (AW - int'(cnt_base) - int'(sz)));
          cnt_nx = cnt_base + CW'(sz);
        end
        if (flush && rdy_out) state_nx = PAD;
      end
      PAD: begin
        // Whole words still pending are emitted first; the tail is padded once.
        if (cnt < CW'(OUT_WIDTH)) begin
          if (cnt != '0) begin
            acc_nx = PAD_BIT ? (acc | pad_fill) : acc;
            cnt_nx = CW'(OUT_WIDTH);
          end
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if ((cnt == '0) && stuff_empty) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        acc_nx   = '0;
        cnt_nx   = '0;
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // State, accumulator and post-reset ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      acc   <= '0;
      cnt   <= '0;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      live  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_code_packer.sv
// Testbench for code_packer (IN_WIDTH=16, OUT_WIDTH=16, PAD_BIT=1).
// Expected words come from a bit-stream model (or constants) queued as codes
// are accepted and popped by an output monitor on each output transfer.
module tb_code_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena_in = 1'b0;
  logic        rdy_out;
  logic [15:0] code = '0;
  logic [4:0]  size = '0;
  logic        flush = 1'b0;
  logic        ena_out;
  logic        rdy_in = 1'b1;
  logic [15:0] out;
  logic        done;

  int vectors = 0;
  int errors  = 0;
  int last_wait = 0;
  bit model_on = 1'b1;
  int nbits = 0;

  bit          bitq[$];
  logic [7:0]  byteq[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  code_packer #(.IN_WIDTH(16), .OUT_WIDTH(16), .PAD_BIT(1'b1)) dut (
    .clk(clk), .rst(rst), .ena_in(ena_in), .rdy_out(rdy_out), .code(code),
    .size(size), .flush(flush), .ena_out(ena_out), .rdy_in(rdy_in),
    .out(out), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void model_byte(input logic [7:0] by);
    byteq.push_back(by);
    if (byteq.size() == 2) begin
      exp_q.push_back({byteq[0], byteq[1]});
      byteq.delete();
    end
  endfunction

  function automatic void model_bit(input bit bv);
    logic [7:0] by;
    bitq.push_back(bv);
    nbits++;
    if (bitq.size() == 8) begin
      for (int i = 0; i < 8; i++) by[7-i] = bitq[i];
      bitq.delete();
      model_byte(by);
`ifdef CODE_PACKER_STUFF_EN
      if (by == 8'hFF) model_byte(8'h00);
`endif
    end
  endfunction

  function automatic void model_add(input logic [15:0] c, input int s);
    int n;
    n = (s > 16) ? 16 : s;
    for (int i = n - 1; i >= 0; i--) model_bit(c[i]);
  endfunction

  function automatic void model_flush();
    while ((nbits % 16) != 0) model_bit(1'b1);
    nbits = 0;
    if (byteq.size() != 0) model_byte(8'h00);
  endfunction

  function automatic void model_clear();
    bitq.delete();
    byteq.delete();
    exp_q.delete();
    nbits = 0;
  endfunction

  // Output monitor: every output transfer is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && ena_out && rdy_in) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got=%h expected=<no word>", out);
      end else begin
        exp_w = exp_q.pop_front();
        if (out !== exp_w) begin
          errors++;
          $display("FAIL out_word got=%h expected=%h", out, exp_w);
        end
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic push_code(input logic [15:0] c, input int s);
    int n = 0;
    ena_in = 1'b1;
    code   = c;
    size   = s[4:0];
    @(negedge clk);
    while (!rdy_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!rdy_out) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout got rdy_out=%b expected=1", rdy_out);
    end else if (model_on) begin
      model_add(c, s);
    end
    @(posedge clk); #1;
    ena_in = 1'b0;
  endtask

  task automatic do_flush(input bit empty_case);
    int k = 0;
    bit saw_out = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    while (!rdy_out && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rdy_out) begin
      errors++;
      $display("FAIL flush_accept_timeout got rdy_out=%b expected=1", rdy_out);
      $fatal(1, "flush never accepted");
    end
    if (model_on) model_flush();
    @(posedge clk); #1;
    flush = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (ena_out) saw_out = 1'b1;
    end while (!done && k < 200);
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout got done=%b expected=1", done);
    end
    if (empty_case) begin
      vectors++;
      if (k != 3) begin
        errors++;
        $display("FAIL done_latency got=%0d edges expected=2 edges after accept", k - 1);
      end
      vectors++;
      if (saw_out) begin
        errors++;
        $display("FAIL empty_flush_word got ena_out=1 expected=0");
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL words_left got=%0d expected=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rdy_out !== 1'b0) begin errors++; $display("FAIL reset_rdy_out got=%b expected=0", rdy_out); end
    vectors++;
    if (ena_out !== 1'b0) begin errors++; $display("FAIL reset_ena_out got=%b expected=0", ena_out); end
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b expected=0", done); end
    rst = 1'b0;
    #1;
    vectors++;
    if (rdy_out !== 1'b0) begin errors++; $display("FAIL rdy_before_edge got=%b expected=0", rdy_out); end
    @(posedge clk); #1;
    vectors++;
    if (rdy_out !== 1'b1) begin errors++; $display("FAIL rdy_after_edge got=%b expected=1", rdy_out); end
  endtask

  task automatic test_example();
    model_on = 1'b0;
`ifdef CODE_PACKER_STUFF_EN
    exp_q.push_back(16'h8030);
    exp_q.push_back(16'h6AAA);
    exp_q.push_back(16'hFF00);
    exp_q.push_back(16'hFF00);
`else
    exp_q.push_back(16'b1000000000110000);
    exp_q.push_back(16'b0110101010101010);
    exp_q.push_back(16'b1111111111111111);
`endif
    push_code(16'b0000010000000001, 11);
    push_code(16'b0000000001000001, 7);
    push_code(16'b1010101010101011, 16);
    do_flush(1'b0);
    model_on = 1'b1;
  endtask

  task automatic test_empty_flush();
    do_flush(1'b1);
  endtask

  task automatic test_size_edges();
    push_code(16'hFFFF, 0);
    push_code(16'h1234, 31);
    push_code(16'hFFF5, 4);
    push_code(16'h0002, 3);
    do_flush(1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      push_code(16'($urandom) & 16'h7F7F, 16);
      vectors++;
      if (last_wait != 0) begin
        errors++;
        $display("FAIL full_rate code=%0d got wait=%0d expected=0", i, last_wait);
      end
    end
    do_flush(1'b0);
    for (int i = 0; i < 25; i++) push_code(16'($urandom), $urandom_range(0, 31));
    do_flush(1'b0);
  endtask

  task automatic test_stall();
    logic [15:0] held;
    bit dropped = 1'b0;
    rdy_in = 1'b0;
    ena_in = 1'b1;
    size   = 5'd16;
    for (int i = 0; i < 6 && !dropped; i++) begin
      code = 16'($urandom);
      @(negedge clk);
      if (rdy_out) begin
        model_add(code, 16);
        @(posedge clk); #1;
      end else begin
        dropped = 1'b1;
      end
    end
    ena_in = 1'b0;
    vectors++;
    if (!dropped) begin errors++; $display("FAIL stall_rdy_out got=1 expected=0"); end
    held = out;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (out !== held || ena_out !== 1'b1 || rdy_out !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got out=%h ena_out=%b rdy_out=%b expected out=%h ena_out=1 rdy_out=0",
                 out, ena_out, rdy_out, held);
      end
    end
    @(posedge clk); #1;
    rdy_in = 1'b1;
    do_flush(1'b0);
  endtask

  task automatic test_reset_mid_drain();
    rdy_in = 1'b0;
    push_code(16'h0015, 5);
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (rdy_out !== 1'b1) begin errors++; $display("FAIL drain_flush_rdy got=%b expected=1", rdy_out); end
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (ena_out !== 1'b1) begin errors++; $display("FAIL drain_pending got ena_out=%b expected=1", ena_out); end
    rst = 1'b1;
    #1;
    vectors++;
    if (ena_out !== 1'b0 || done !== 1'b0 || rdy_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort got ena_out=%b done=%b rdy_out=%b expected=0 0 0", ena_out, done, rdy_out);
    end
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rdy_in = 1'b1;
    push_code(16'hC3A5, 16);
    push_code(16'h0006, 3);
    do_flush(1'b0);
  endtask

  initial begin
    test_reset();
    test_example();
    test_empty_flush();
    test_size_edges();
    test_back_to_back();
    test_stall();
    test_reset_mid_drain();
    test_empty_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/code_packer.md
CODE_PACKER -- requirements
Module: code_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, max code length in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, output word width; multiple of 8, >= 8.
REQ-003 SHALL have parameter PAD_BIT, default 1'b1, fill bit used on flush.
REQ-004 clk  input  1  clock, one clock domain; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ena_in  input  1  input code valid.
REQ-007 rdy_out  output  1  block ready to accept code/flush.
REQ-008 code  input  IN_WIDTH  code, right-aligned; bits at or above size ignored.
REQ-009 size  input  $clog2(IN_WIDTH+1)  code length in bits.
REQ-010 flush  input  1  pad and drain request.
REQ-011 ena_out  output  1  output word valid.
REQ-012 rdy_in  input  1  downstream ready.
REQ-013 out  output  OUT_WIDTH  packed word, first-packed bit at MSB.
REQ-014 done  output  1  one-cycle pulse: flush complete.

Function
REQ-015 Input transfer SHALL occur when ena_in && rdy_out; output transfer when ena_out && rdy_in.
REQ-016 Accumulator SHALL be OUT_WIDTH+IN_WIDTH bits, MSB-first, with fill count cnt.
REQ-017 Accepted code SHALL be appended at bit position cnt, MSB of code first; size 0 is an accepted no-op; size > IN_WIDTH clamps to IN_WIDTH.
REQ-018 ena_out SHALL assert while cnt >= OUT_WIDTH (no stuffing); out = top OUT_WIDTH bits, held stable while ena_out && !rdy_in.
REQ-019 Simultaneous accept and emit SHALL give cnt_next = cnt + size - OUT_WIDTH in the same cycle; sustained one code/cycle with rdy_in high.
REQ-020 rdy_out SHALL be high only in state RUN with cnt <= OUT_WIDTH, or cnt <= OUT_WIDTH+... excluded: never accept if overflow possible.
REQ-021 FSM states RUN, PAD, DRAIN, DONE; RUN->PAD on flush && rdy_out (code with ena_in same cycle is packed first).
REQ-022 PAD: cnt not multiple of OUT_WIDTH -> pad with PAD_BIT to next OUT_WIDTH boundary in one cycle; cnt==0 -> no padding, no word; -> DRAIN.
REQ-023 DRAIN: emit remaining words (and stuffer contents); when empty -> DONE.
REQ-024 DONE: done=1 one cycle, accumulator cleared, -> RUN; rdy_out low from flush acceptance through DONE.
REQ-025 Flush with empty accumulator SHALL produce done exactly 2 cycles after acceptance, no ena_out.

Reset
REQ-026 While rst high: state RUN, cnt 0, accumulator 0, stuffer empty, ena_out 0, done 0, rdy_out 0.
REQ-027 rdy_out SHALL rise the first clock edge after rst deasserts; reset mid-flush aborts all pending data.

Configuration
REQ-028 Macro CODE_PACKER_STUFF_EN SHALL compile in byte stuffing: each output byte 0xFF followed by byte 0x00 in the stream.
REQ-029 With macro: words pass through a stuffer adding exactly one cycle latency; stuffed bytes straddle word boundaries; DRAIN pads a final partial stuffed word with 0x00 bytes... not PAD_BIT.
REQ-030 Without macro: no stuffer logic present; out taken directly from accumulator, zero added latency.

Structure
REQ-031 Package code_packer_pkg SHALL hold FSM state enum and size-width/byte-lane count helper constants.
REQ-032 Sub-module byte_stuffer (valid/ready both sides, byte buffer 3*OUT_WIDTH/8-1 deep) instantiated only under CODE_PACKER_STUFF_EN.

Verification (IN_WIDTH=16, OUT_WIDTH=16, PAD_BIT=1)
REQ-033 Codes (11,10000000001),(7,1000001),(16,1010101010101011), flush -> words 1000000000110000, 0110101010101010, 1111111111111111, then done.
REQ-034 Same with CODE_PACKER_STUFF_EN -> 0x8030, 0x6AAA, 0xFF00, 0xFF00, then done.
REQ-035 Stream 16-bit codes, rdy_in low 3 cycles -> rdy_out drops once cnt > 16, out stable, no bits lost or duplicated.
REQ-036 Flush with cnt=0 -> no ena_out, done 2 cycles after acceptance.
REQ-037 size=0 and size=31 codes -> no-op and clamp to 16 bits respectively.
REQ-038 rst asserted mid-DRAIN -> ena_out, done, cnt 0 immediately; next stream packs from empty.
